// File: rtl/viterbi_pkg.sv
// rtl/viterbi_pkg.sv - shared types and constants for the noisy-channel injector
package viterbi_pkg;

    typedef enum logic [1:0] {
        CH_OFF      = 2'd0,
        CH_PERIODIC = 2'd1,
        CH_BURST    = 2'd2,
        CH_RANDOM   = 2'd3
    } chan_mode_e;

    typedef enum logic [1:0] {
        S_OFF   = 2'd0,
        S_GAP   = 2'd1,
        S_BURST = 2'd2
    } inj_state_e;

    localparam logic [15:0] LFSR_SEED_DEF = 16'h0001;
    localparam logic [15:0] LFSR_TAPS     = 16'hB400;

    // An all-zero seed would lock the LFSR at zero forever.
    function automatic logic [15:0] lfsr_seed_fix(input logic [15:0] seed);
        return (seed == 16'h0000) ? LFSR_SEED_DEF : seed;
    endfunction

endpackage

// File: rtl/chan_lfsr16.sv
// rtl/chan_lfsr16.sv - 16-bit right-shifting Galois LFSR with load and step
module chan_lfsr16
    import viterbi_pkg::*;
(
    input  logic        clk,
    input  logic        load_i,
    input  logic [15:0] seed_i,
    input  logic        step_i,
    output logic [15:0] state_o
);

    logic [15:0] lfsr_q;
    logic [15:0] lfsr_d;

    // Load has priority so a reseed in the same cycle as a step starts clean.
    always_comb begin
        lfsr_d = lfsr_q;
        if (load_i) begin
            lfsr_d = seed_i;
        end else if (step_i) begin
            lfsr_d = lfsr_q[0] ? ((lfsr_q >> 1) ^ LFSR_TAPS) : (lfsr_q >> 1);
        end
    end

    always_ff @(posedge clk) begin
        lfsr_q <= lfsr_d;
    end

    assign state_o = lfsr_q;

endmodule

// File: rtl/viterbi_channel_inj.sv
// rtl/viterbi_channel_inj.sv - noisy-channel model flipping encoded symbol bits by mode
module viterbi_channel_inj
    import viterbi_pkg::*;
#(
    parameter int SYM_W = 2,
    parameter int PER_W = 8,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cfg_load_i,
    input  logic [1:0]       mode_i,
    input  logic [PER_W-1:0] period_i,
    input  logic [PER_W-1:0] burst_len_i,
    input  logic [SYM_W-1:0] bit_mask_i,
    input  logic [7:0]       ber_thresh_i,
    input  logic [15:0]      seed_i,
    input  logic             valid_i,
    input  logic [SYM_W-1:0] sym_i,
    output logic             valid_o,
    output logic [SYM_W-1:0] sym_o,
    output logic [SYM_W-1:0] err_o,
    output logic [CNT_W-1:0] sym_cnt_o,
    output logic [CNT_W-1:0] err_cnt_o
);

    chan_mode_e       mode_q, mode_d;
    logic [PER_W-1:0] period_q, period_d;
    logic [PER_W-1:0] burst_q, burst_d;
    logic [SYM_W-1:0] mask_q, mask_d;
    logic [7:0]       thresh_q, thresh_d;
    logic [PER_W-1:0] ph_q, ph_d;
    inj_state_e       state_q, state_d;
    logic             valid_q, valid_d;
    logic [SYM_W-1:0] sym_q, sym_d;
    logic [SYM_W-1:0] err_q, err_d;
    logic [CNT_W-1:0] sym_cnt_q, sym_cnt_d;
    logic [CNT_W-1:0] err_cnt_q, err_cnt_d;
    logic [CNT_W-1:0] err_pop;

    logic             lfsr_load;
    logic [15:0]      lfsr_base_seed;
    logic [15:0]      lfsr_state [SYM_W];

    // The state describes the symbol at phase ph: inside the last eb slots of the period.
    function automatic inj_state_e classify(
        input chan_mode_e       m,
        input logic [PER_W-1:0] p,
        input logic [PER_W-1:0] b,
        input logic [PER_W-1:0] ph
    );
        logic [PER_W-1:0] eb;
        eb = '0;
        if (m == CH_PERIODIC) begin
            eb = PER_W'(1);
        end else if (m == CH_BURST) begin
            eb = (b > p) ? p : b;
        end
        if (((m != CH_PERIODIC) && (m != CH_BURST)) || (p == '0) || (eb == '0)) begin
            return S_OFF;
        end
        return (ph >= (p - eb)) ? S_BURST : S_GAP;
    endfunction

    function automatic logic [CNT_W-1:0] sat_add(
        input logic [CNT_W-1:0] a,
        input logic [CNT_W-1:0] b
    );
        logic [CNT_W:0] s;
        s = {1'b0, a} + {1'b0, b};
        return s[CNT_W] ? '1 : s[CNT_W-1:0];
    endfunction

    assign lfsr_load      = rst | cfg_load_i;
    assign lfsr_base_seed = rst ? LFSR_SEED_DEF : lfsr_seed_fix(seed_i);

    for (genvar k = 0; k < SYM_W; k++) begin : g_lfsr
        localparam int ROT = k % 16;
        logic [31:0] seed_dbl;
        logic [15:0] seed_rot;
        assign seed_dbl = {lfsr_base_seed, lfsr_base_seed};
        assign seed_rot = seed_dbl[31-ROT -: 16];

        chan_lfsr16 u_lfsr (
            .clk     (clk),
            .load_i  (lfsr_load),
            .seed_i  (seed_rot),
            .step_i  (valid_i),
            .state_o (lfsr_state[k])
        );
    end

    always_comb begin
        mode_d   = mode_q;
        period_d = period_q;
        burst_d  = burst_q;
        mask_d   = mask_q;
        thresh_d = thresh_q;
        if (cfg_load_i) begin
            mode_d   = chan_mode_e'(mode_i);
            period_d = period_i;
            burst_d  = burst_len_i;
            mask_d   = bit_mask_i;
            thresh_d = ber_thresh_i;
        end

        ph_d = ph_q;
        if (valid_i) begin
            if ((period_q == '0) || (ph_q >= (period_q - PER_W'(1)))) begin
                ph_d = '0;
            end else begin
                ph_d = ph_q + PER_W'(1);
            end
        end
        if (cfg_load_i) begin
            ph_d = '0;
        end
        state_d = classify(mode_d, period_d, burst_d, ph_d);

        // The current symbol always sees the configuration in force before any load.
        err_d = '0;
        if (valid_i) begin
            if (mode_q == CH_RANDOM) begin
                for (int k = 0; k < SYM_W; k++) begin
                    err_d[k] = mask_q[k] & (lfsr_state[k][7:0] < thresh_q);
                end
            end else if (state_q == S_BURST) begin
                err_d = mask_q;
            end
        end

        valid_d = valid_i;
        sym_d   = valid_i ? (sym_i ^ err_d) : '0;

        err_pop = '0;
        for (int k = 0; k < SYM_W; k++) begin
            err_pop = err_pop + CNT_W'(err_d[k]);
        end

        sym_cnt_d = sat_add(sym_cnt_q, CNT_W'(valid_i));
        err_cnt_d = sat_add(err_cnt_q, err_pop);
        if (cfg_load_i) begin
            sym_cnt_d = '0;
            err_cnt_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mode_q    <= CH_OFF;
            period_q  <= '0;
            burst_q   <= '0;
            mask_q    <= '0;
            thresh_q  <= '0;
            ph_q      <= '0;
            state_q   <= S_OFF;
            valid_q   <= 1'b0;
            sym_q     <= '0;
            err_q     <= '0;
            sym_cnt_q <= '0;
            err_cnt_q <= '0;
        end else begin
            mode_q    <= mode_d;
            period_q  <= period_d;
            burst_q   <= burst_d;
            mask_q    <= mask_d;
            thresh_q  <= thresh_d;
            ph_q      <= ph_d;
            state_q   <= state_d;
            valid_q   <= valid_d;
            sym_q     <= sym_d;
            err_q     <= err_d;
            sym_cnt_q <= sym_cnt_d;
            err_cnt_q <= err_cnt_d;
        end
    end

    assign valid_o   = valid_q;
    assign sym_o     = sym_q;
    assign err_o     = err_q;
    assign sym_cnt_o = sym_cnt_q;
    assign err_cnt_o = err_cnt_q;

endmodule

// File: tb/tb_viterbi_channel_inj.sv
// tb/tb_viterbi_channel_inj.sv - self-checking bench for viterbi_channel_inj
module tb_viterbi_channel_inj;

    logic        clk = 1'b0;
    logic        rst;
    logic        cfg_load_i;
    logic [1:0]  mode_i;
    logic [7:0]  period_i;
    logic [7:0]  burst_len_i;
    logic [1:0]  bit_mask_i;
    logic [7:0]  ber_thresh_i;
    logic [15:0] seed_i;
    logic        valid_i;
    logic [1:0]  sym_i;

    logic        valid_o, valid4_o;
    logic [1:0]  sym_o, sym4_o, err_o, err4_o;
    logic [15:0] sym_cnt_o, err_cnt_o;
    logic [3:0]  sym_cnt4_o, err_cnt4_o;

    int tests = 0;
    int fails = 0;

    // Reference model: channel rules in terms of symbol index since config load
    int m_mode, m_period, m_burst, m_mask, m_thresh;
    int m_n, m_sym, m_err;
    int m_lf [2];
    bit rec_on;
    int rec_q [$];

    always #5 clk = ~clk;

    viterbi_channel_inj dut (
        .clk(clk), .rst(rst), .cfg_load_i(cfg_load_i), .mode_i(mode_i),
        .period_i(period_i), .burst_len_i(burst_len_i), .bit_mask_i(bit_mask_i),
        .ber_thresh_i(ber_thresh_i), .seed_i(seed_i), .valid_i(valid_i), .sym_i(sym_i),
        .valid_o(valid_o), .sym_o(sym_o), .err_o(err_o),
        .sym_cnt_o(sym_cnt_o), .err_cnt_o(err_cnt_o)
    );

    viterbi_channel_inj #(.CNT_W(4)) dut4 (
        .clk(clk), .rst(rst), .cfg_load_i(cfg_load_i), .mode_i(mode_i),
        .period_i(period_i), .burst_len_i(burst_len_i), .bit_mask_i(bit_mask_i),
        .ber_thresh_i(ber_thresh_i), .seed_i(seed_i), .valid_i(valid_i), .sym_i(sym_i),
        .valid_o(valid4_o), .sym_o(sym4_o), .err_o(err4_o),
        .sym_cnt_o(sym_cnt4_o), .err_cnt_o(err_cnt4_o)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic int rotl16(input int s, input int k);
        if (k == 0) return s & 16'hFFFF;
        return ((s << k) | (s >> (16 - k))) & 16'hFFFF;
    endfunction

    function automatic int lfsr_next(input int s);
        return (s & 1) ? ((s >> 1) ^ 16'hB400) : (s >> 1);
    endfunction

    function automatic int min_i(input int a, input int b);
        return (a < b) ? a : b;
    endfunction

    task automatic model_seed(input int seed);
        int s;
        s = (seed == 0) ? 1 : seed;
        for (int k = 0; k < 2; k++) m_lf[k] = rotl16(s, k);
    endtask

    // One clock: apply inputs, then compare every output against the model.
    task automatic send(input bit v, input logic [1:0] s, input bit ld, input bit r);
        int e, pos, eb;
        e = 0;
        valid_i = v; sym_i = s; cfg_load_i = ld; rst = r;
        @(posedge clk);
        #1;
        if (r) begin
            m_mode = 0; m_period = 0; m_burst = 0; m_mask = 0; m_thresh = 0;
            m_n = 0; m_sym = 0; m_err = 0;
            model_seed(1);
        end else begin
            if (v) begin
                if (m_mode == 3) begin
                    for (int k = 0; k < 2; k++)
                        if (m_mask[k] && ((m_lf[k] & 255) < m_thresh)) e |= (1 << k);
                end else if (m_mode == 1 || m_mode == 2) begin
                    eb = (m_mode == 1) ? 1 : min_i(m_burst, m_period);
                    if (m_period > 0 && eb > 0) begin
                        pos = m_n % m_period;
                        if (pos >= m_period - eb) e = m_mask;
                    end
                end
                m_n++;
                for (int k = 0; k < 2; k++) m_lf[k] = lfsr_next(m_lf[k]);
                m_sym++;
                m_err += $countones(e[1:0]);
            end
            if (ld) begin
                m_mode = mode_i; m_period = period_i; m_burst = burst_len_i;
                m_mask = bit_mask_i; m_thresh = ber_thresh_i;
                m_n = 0; m_sym = 0; m_err = 0;
                model_seed(seed_i);
            end
        end
        chk("valid_o", valid_o, (!r && v) ? 1 : 0);
        chk("err_o", err_o, (!r && v) ? e : 0);
        chk("sym_o", sym_o, (!r && v) ? (s ^ e[1:0]) : 0);
        chk("sym_cnt_o", sym_cnt_o, min_i(m_sym, 65535));
        chk("err_cnt_o", err_cnt_o, min_i(m_err, 65535));
        chk("sym_cnt4_o", sym_cnt4_o, min_i(m_sym, 15));
        chk("err_cnt4_o", err_cnt4_o, min_i(m_err, 15));
        if (rec_on && v) rec_q.push_back(int'(err_o));
    endtask

    task automatic load(input int md, input int per, input int bl, input int mk,
                        input int th, input int sd);
        mode_i = md[1:0]; period_i = per[7:0]; burst_len_i = bl[7:0];
        bit_mask_i = mk[1:0]; ber_thresh_i = th[7:0]; seed_i = sd[15:0];
        send(0, 2'b00, 1, 0);
        // Scramble cfg inputs afterwards: they must be ignored without a load.
        mode_i = 2'($urandom); period_i = 8'($urandom); burst_len_i = 8'($urandom);
        bit_mask_i = 2'($urandom); ber_thresh_i = 8'($urandom); seed_i = 16'($urandom);
    endtask

    task automatic run_syms(input int count, input bit gaps);
        int sent;
        bit v;
        sent = 0;
        while (sent < count) begin
            v = gaps ? ($urandom_range(0, 3) != 0) : 1'b1;
            send(v, 2'($urandom), 0, 0);
            if (v) sent++;
        end
    endtask

    initial begin
        int first_q [$];
        rec_on = 0;
        mode_i = 0; period_i = 0; burst_len_i = 0; bit_mask_i = 0;
        ber_thresh_i = 0; seed_i = 0;
        send(0, 0, 0, 1);
        send(1, 2'b11, 0, 1);

        // Reset state holds OFF even with valid traffic
        run_syms(5, 1);

        // 1: OFF
        load(0, 16, 3, 3, 255, 16'h1234);
        run_syms(256, 1);
        chk("off_sym_cnt", sym_cnt_o, 256);
        chk("off_err_cnt", err_cnt_o, 0);

        // 2: PERIODIC period 16 mask 10
        load(1, 16, 0, 2, 0, 1);
        run_syms(256, 1);
        chk("per_err_cnt", err_cnt_o, 16);

        // 3: BURST period 10 burst 3 mask 11
        load(2, 10, 3, 3, 0, 1);
        run_syms(100, 1);
        chk("burst_err_cnt", err_cnt_o, 60);

        // burst_len > period and period 1 corrupt every symbol; period 0 never
        load(2, 4, 9, 1, 0, 1);
        run_syms(12, 0);
        chk("burst_gt_per", err_cnt_o, 12);
        load(1, 1, 0, 3, 0, 1);
        run_syms(7, 1);
        chk("period_one", err_cnt_o, 14);
        load(2, 0, 5, 3, 0, 1);
        run_syms(20, 1);
        chk("period_zero", err_cnt_o, 0);

        // 4: RANDOM, then repeat with the same seed
        load(3, 0, 0, 3, 26, 16'hACE1);
        rec_on = 1;
        run_syms(10000, 0);
        rec_on = 0;
        chk("ber_in_range", (err_cnt_o >= 1880 && err_cnt_o <= 2180) ? 1 : 0, 1);
        first_q = rec_q;
        rec_q.delete();
        load(3, 0, 0, 3, 26, 16'hACE1);
        rec_on = 1;
        run_syms(300, 1);
        rec_on = 0;
        for (int i = 0; i < 300; i++) chk("rand_repeat", rec_q[i], first_q[i]);
        rec_q.delete();

        // 5: load with a same-cycle symbol uses the old config
        load(1, 2, 0, 3, 0, 1);
        run_syms(1, 0);
        mode_i = 0; period_i = 5; burst_len_i = 0; bit_mask_i = 0;
        ber_thresh_i = 0; seed_i = 1;
        send(1, 2'b01, 1, 0);
        chk("ld_old_err", err_o, 3);
        chk("ld_cnt_clear", sym_cnt_o, 0);
        run_syms(3, 0);
        load(1, 3, 0, 1, 0, 1);
        run_syms(2, 0);
        chk("ph_restart_gap", err_cnt_o, 0);
        run_syms(1, 0);
        chk("ph_restart_hit", err_cnt_o, 1);

        // Seed 0 behaves as seed 1
        load(3, 0, 0, 3, 128, 0);
        rec_on = 1;
        run_syms(64, 0);
        rec_on = 0;
        first_q = rec_q;
        rec_q.delete();
        load(3, 0, 0, 3, 128, 1);
        rec_on = 1;
        run_syms(64, 1);
        rec_on = 0;
        for (int i = 0; i < 64; i++) chk("seed0_eq_seed1", rec_q[i], first_q[i]);
        rec_q.delete();

        // 6: reset mid-burst, then saturation of the narrow counters
        load(2, 10, 3, 3, 0, 1);
        run_syms(8, 0);
        chk("in_burst", err_o, 3);
        send(1, 2'b10, 0, 1);
        chk("rst_valid", valid_o, 0);
        chk("rst_cnt", err_cnt_o, 0);
        run_syms(12, 1);
        chk("post_rst_off", err_cnt_o, 0);
        load(2, 1, 1, 3, 0, 1);
        run_syms(20, 1);
        chk("sat_sym4", sym_cnt4_o, 15);
        chk("sat_err4", err_cnt4_o, 15);
        send(1, 2'b00, 0, 1);
        run_syms(3, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
